idma_sram_rd_stream: RTL and testbench



---
 rtl/idma_sram_rd_stream_pkg.sv | 20 ++
 rtl/idma_sram_rd_stream_if.sv | 33 +++
 rtl/idma_sync_fifo.sv | 59 +++++
 rtl/idma_sram_rd_stream.sv | 117 +++++++++++
 tb/tb_idma_sram_rd_stream.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/idma_sram_rd_stream_pkg.sv
// Shared iDMA definitions: staging SRAM geometry, read-engine FSM states and
// the output FIFO entry layout.
package idma_sram_rd_stream_pkg;

  localparam int SRAM_DEPTH = 1024;
  localparam int SRAM_AW    = 10;
  localparam int SRAM_DW    = 128;
  localparam int SRAM_STRB  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [SRAM_DW-1:0] data;
    logic               last;
  } fifo_entry_t;

endpackage

// File: rtl/idma_sram_rd_stream_if.sv
// Command, SRAM read port and output stream of the iDMA SRAM read engine.
// The master modport is the engine; the slave modport is its surroundings.
interface idma_sram_rd_stream_if
  import idma_sram_rd_stream_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, sram_rdata, out_ready,
    output cmd_ready, sram_cen, sram_wen, sram_addr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, sram_rdata, out_ready,
    input  cmd_ready, sram_cen, sram_wen, sram_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/idma_sync_fifo.sv
// Register FIFO with occupancy count; pop on empty is ignored, push is never
// refused (the producer guarantees space).
module idma_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok   = pop && (count_reg != '0);
  assign pop_data = mem_reg[rd_ptr_reg];
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/idma_sram_rd_stream.sv
// Burst read engine: SRAM reads paced by FIFO credit, data streamed out with a
// last marker. Optional stall counter under `ifdef IDMA_SRAM_RD_PERF_EN.
module idma_sram_rd_stream
  import idma_sram_rd_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = SRAM_AW,
  parameter int DW         = SRAM_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  idma_sram_rd_stream_if.master bus
`ifdef IDMA_SRAM_RD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DW + 1;

  state_e        state_reg;
  logic          cmd_ready_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] beats_left_reg;
  logic [AW-1:0] addr_hold_reg;
  logic          pend_reg;
  logic          pend_last_reg;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [EW-1:0] fifo_head;
  fifo_entry_t   head;
  logic [CW:0]   occupancy;
  logic          credit;
  logic          issue;
  logic          issue_last;
  logic          pop;

  // A read in flight (pend) already owns a FIFO slot.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, pend_reg};
  assign credit     = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign issue      = (state_reg == BURST) && credit;
  assign issue_last = issue && (beats_left_reg == '0);
  assign pop        = !fifo_empty && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cmd_ready_reg  <= 1'b1;
      rd_ptr_reg     <= '0;
      beats_left_reg <= '0;
      addr_hold_reg  <= '0;
      pend_reg       <= 1'b0;
      pend_last_reg  <= 1'b0;
    end else begin
      pend_reg      <= issue;
      pend_last_reg <= issue_last;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_ptr_reg     <= bus.cmd_addr;
            beats_left_reg <= bus.cmd_len;
            cmd_ready_reg  <= 1'b0;
            state_reg      <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            rd_ptr_reg     <= rd_ptr_reg + 1'b1;
            beats_left_reg <= beats_left_reg - 1'b1;
            addr_hold_reg  <= rd_ptr_reg;
            if (beats_left_reg == '0) begin
              cmd_ready_reg <= 1'b1;
              state_reg     <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  idma_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_reg),
    .push_data ({bus.sram_rdata, pend_last_reg}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head          = fifo_head;
  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.sram_cen  = issue;
  assign bus.sram_wen  = 1'b0;
  assign bus.sram_addr = issue ? rd_ptr_reg : addr_hold_reg;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;

`ifdef IDMA_SRAM_RD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (!fifo_empty && !bus.out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idma_sram_rd_stream.sv
// Directed bench for idma_sram_rd_stream: table of bursts plus hand-written
// back-to-back and mid-burst reset sequences against an SRAM model.
module tb_idma_sram_rd_stream;
  import idma_sram_rd_stream_pkg::*;

  localparam int FD = 4;

  typedef struct {
    logic [9:0] addr;
    logic [9:0] len;
    int         mode;            // 0 ready=1, 1 random ready, 2 stall 20 cycles
    int         exp_beats;
    logic [9:0] exp_end;         // last SRAM row read
    int         exp_done;        // last handshake offset from T (0 = unchecked)
    int         exp_stall_reads; // reads during stall (0 = unchecked)
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idma_sram_rd_stream_if #(.AW(10), .DW(128)) bus();

`ifdef IDMA_SRAM_RD_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  idma_sram_rd_stream #(.FIFO_DEPTH(FD), .AW(10), .DW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IDMA_SRAM_RD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [127:0] mem [1024];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, garbage on non-read cycles
  always @(posedge clk) begin
    if (bus.sram_cen) bus.sram_rdata <= mem[bus.sram_addr];
    else              bus.sram_rdata <= {4{$urandom}};
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int ready_mode = 0;
  int stall_until = 0;
  int stall_cen;
  int max_out;
  logic [9:0]   cen_addr_q [$];
  int           cen_cyc_q  [$];
  logic [128:0] beat_q     [$];
  int           beat_cyc_q [$];
  int           hs_q       [$];
  vec_t         vecs [6];

  function automatic logic [127:0] pat(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {u * 32'h9E3779B1, ~u, u ^ 32'h5A5A5A5A, 32'hC0DE0000 | u};
  endfunction

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic clear_mon();
    cen_addr_q.delete(); cen_cyc_q.delete(); beat_q.delete(); beat_cyc_q.delete(); hs_q.delete();
    stall_cen = 0;
    max_out = 0;
  endtask

  // Entered at posedge+1: sample at negedge, then drive next cycle's out_ready.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) hs_q.push_back(cyc);
      if (bus.sram_cen) begin
        cen_addr_q.push_back(bus.sram_addr);
        cen_cyc_q.push_back(cyc);
        if (cyc < stall_until) stall_cen++;
      end
      if (cen_addr_q.size() - beat_q.size() > max_out) max_out = cen_addr_q.size() - beat_q.size();
      if (bus.out_valid && bus.out_ready) begin
        beat_q.push_back({bus.out_last, bus.out_data});
        beat_cyc_q.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = (cyc >= stall_until);
    endcase
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 6000 && beat_q.size() < n; k++) tick();
    repeat (6) tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    logic [9:0] row;
    clear_mon();
    ready_mode  = v.mode;
    stall_until = cyc + 20;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50 && hs_q.size() == 0; k++) tick();
    bus.cmd_valid = 1'b0;
    chk({tag, " accepted"}, 128'(hs_q.size()), 128'd1);
    if (hs_q.size() == 0) return;
    t0 = hs_q[0];
    wait_beats(v.exp_beats);
    chk({tag, " beats"}, 128'(beat_q.size()), 128'(v.exp_beats));
    chk({tag, " reads"}, 128'(cen_addr_q.size()), 128'(v.exp_beats));
    for (int i = 0; i < cen_addr_q.size() && i < v.exp_beats; i++) begin
      row = v.addr + 10'(i);
      chk($sformatf("%s addr%0d", tag, i), 128'(cen_addr_q[i]), 128'(row));
    end
    if (cen_addr_q.size() > 0) chk({tag, " end addr"}, 128'(cen_addr_q[$]), 128'(v.exp_end));
    for (int i = 0; i < beat_q.size() && i < v.exp_beats; i++) begin
      row = v.addr + 10'(i);
      chk($sformatf("%s data%0d", tag, i), beat_q[i][127:0], pat(int'(row)));
      chk($sformatf("%s last%0d", tag, i), 128'(beat_q[i][128]), 128'(i == v.exp_beats - 1));
    end
    chk({tag, " credit"}, 128'(max_out <= FD), 128'd1);
    if (v.exp_stall_reads != 0) chk({tag, " stall reads"}, 128'(stall_cen), 128'(v.exp_stall_reads));
    if (v.exp_done != 0 && cen_cyc_q.size() > 0 && beat_cyc_q.size() > 0) begin
      chk({tag, " first read"}, 128'(cen_cyc_q[0] - t0), 128'd1);
      chk({tag, " last read"}, 128'(cen_cyc_q[$] - t0), 128'(v.exp_beats));
      chk({tag, " first beat"}, 128'(beat_cyc_q[0] - t0), 128'd3);
      chk({tag, " last beat"}, 128'(beat_cyc_q[$] - t0), 128'(v.exp_done));
    end
  endtask

  initial begin
    int rows [5];
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{10'h010, 10'd3,    0, 4,    10'h013, 6, 0};
    vecs[1] = '{10'h3FE, 10'd3,    0, 4,    10'h001, 6, 0};
    vecs[2] = '{10'h020, 10'd15,   2, 16,   10'h02F, 0, 4};
    vecs[3] = '{10'h000, 10'd1023, 1, 1024, 10'h3FF, 0, 0};
    vecs[4] = '{10'h100, 10'd0,    0, 1,    10'h100, 3, 0};
    vecs[5] = '{10'h3FF, 10'd1,    0, 2,    10'h000, 4, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", 128'(bus.cmd_ready), 128'd1);
    chk("rst sram_cen",  128'(bus.sram_cen),  128'd0);
    chk("rst sram_wen",  128'(bus.sram_wen),  128'd0);
    chk("rst sram_addr", 128'(bus.sram_addr), 128'd0);
    chk("rst out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst out_data",  bus.out_data,        128'd0);
    chk("rst out_last",  128'(bus.out_last),  128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // back-to-back commands A (2 beats) and B (3 beats)
    clear_mon();
    ready_mode = 0;
    bus.cmd_addr = 10'h200; bus.cmd_len = 10'd1; bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50 && hs_q.size() < 1; k++) tick();
    bus.cmd_addr = 10'h300; bus.cmd_len = 10'd2;
    for (int k = 0; k < 50 && hs_q.size() < 2; k++) tick();
    bus.cmd_valid = 1'b0;
    wait_beats(5);
    chk("b2b accepts", 128'(hs_q.size()), 128'd2);
    if (hs_q.size() == 2) chk("b2b B accept cycle", 128'(hs_q[1] - hs_q[0]), 128'd3);
    chk("b2b beats", 128'(beat_q.size()), 128'd5);
    rows = '{32'h200, 32'h201, 32'h300, 32'h301, 32'h302};
    for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
      chk($sformatf("b2b data%0d", i), beat_q[i][127:0], pat(rows[i]));
      chk($sformatf("b2b last%0d", i), 128'(beat_q[i][128]), 128'(i == 1 || i == 4));
    end

    // reset asserted while beat 3 of 8 is on the output
    clear_mon();
    ready_mode = 0;
    bus.cmd_addr = 10'h040; bus.cmd_len = 10'd7; bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50 && hs_q.size() < 1; k++) tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 50 && beat_q.size() < 2; k++) tick();
    chk("rstmid pre cen", 128'(bus.sram_cen), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid out_valid", 128'(bus.out_valid), 128'd0);
    chk("rstmid sram_cen",  128'(bus.sram_cen),  128'd0);
    chk("rstmid out_last",  128'(bus.out_last),  128'd0);
    chk("rstmid cmd_ready", 128'(bus.cmd_ready), 128'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(vecs[0], "post-reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
